// File: rtl/cnn_pkg.sv
// Shared CNN feature-map types and defaults: arbiter FSM states, requester
// indices and the address/data widths the stage engines agree on.
package cnn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned REQ_CONV  = 0;
  localparam int unsigned REQ_RELU  = 1;
  localparam int unsigned REQ_POOL  = 2;
  localparam int unsigned REQ_DENSE = 3;

  localparam int unsigned FMAP_NREQ      = 4;
  localparam int unsigned FMAP_AW        = 12;
  localparam int unsigned FMAP_DW        = 16;
  localparam int unsigned FMAP_MAX_BURST = 16;

endpackage

// File: rtl/fmap_mem_arbiter_if.sv
// Requester/RAM bus of the feature-map arbiter. The arbiter takes the slave
// view; stage engines and the BRAM together form the master side.
interface fmap_mem_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 12,
  parameter int unsigned DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    last;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               busy;

  modport slave (
    input  req, last, we, addr, wdata, mem_rdata,
    output gnt, mem_en, mem_we, mem_addr, mem_wdata, rvalid, rdata, busy
  );

  modport master (
    output req, last, we, addr, wdata, mem_rdata,
    input  gnt, mem_en, mem_we, mem_addr, mem_wdata, rvalid, rdata, busy
  );
endinterface

// File: rtl/fmap_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req upward from ptr with wrap and
// returns the first asserted requester as a one-hot winner.
module rr_pick
  import cnn_pkg::*;
#(
  parameter int unsigned NREQ = FMAP_NREQ,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] winner_o,
  output logic            valid_o
);

  logic [PW-1:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(ptr_i) + i) % NREQ);
      if (!valid_o && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmap_mem_arbiter.sv
// Round-robin arbiter sharing the single-port feature-map RAM between stage
// engines. Define ARB_BURST_LIMIT_EN to force-release a grant after MAX_BURST beats.
module fmap_mem_arbiter
  import cnn_pkg::*;
#(
  parameter int unsigned NREQ      = FMAP_NREQ,
  parameter int unsigned AW        = FMAP_AW,
  parameter int unsigned DW        = FMAP_DW,
  parameter int unsigned MAX_BURST = FMAP_MAX_BURST
) (
  input  logic                clk,
  input  logic                reset,
  fmap_mem_arbiter_if.slave   bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [NREQ-1:0] rtag_q, rtag_d;
  logic [NREQ-1:0] rvalid_q;

  logic [NREQ-1:0] pick_win;
  logic            pick_valid;
  logic            g_req, g_last, g_we;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_wdata;
  logic [PW-1:0]   g_idx;
  logic            beat, limit_hit, rel;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (pick_win),
    .valid_o  (pick_valid)
  );

  // gnt_q is one-hot (or zero), so masking with it selects the granted lane
  always_comb begin
    g_req   = |(bus.req  & gnt_q);
    g_last  = |(bus.last & gnt_q);
    g_we    = |(bus.we   & gnt_q);
    g_addr  = '0;
    g_wdata = '0;
    g_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        g_addr  = bus.addr[i*AW +: AW];
        g_wdata = bus.wdata[i*DW +: DW];
        g_idx   = PW'(i);
      end
    end
  end

  assign beat = (state_q == GRANT) && g_req;

`ifdef ARB_BURST_LIMIT_EN
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (beat)       cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // releases in the same cycle the MAX_BURST-th beat issues
  assign limit_hit = beat && (cnt_q == CW'(MAX_BURST - 1));
`else
  assign limit_hit = 1'b0;
`endif

  assign rel = (state_q == GRANT) && (!g_req || (beat && g_last) || limit_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rtag_q      <= '0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rtag_q      <= rtag_d;
      rvalid_q    <= rtag_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = GRANT;
      GRANT:   if (rel)        state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    mem_en_d    = beat;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rtag_d      = '0;
    if (state_q == IDLE) gnt_d = pick_win;
    if (beat) begin
      mem_we_d    = g_we;
      mem_addr_d  = g_addr;
      mem_wdata_d = g_wdata;
      rtag_d      = g_we ? '0 : gnt_q;
    end
    if (rel) begin
      gnt_d = '0;
      ptr_d = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.busy      = (state_q == GRANT) | mem_en_q | (|rtag_q) | (|rvalid_q);

endmodule

// File: doc/fmap_mem_arbiter.md
# fmap_mem_arbiter

Round-robin arbiter that shares the single-port feature-map RAM between the CNN stage engines (conv, relu, pool, dense). Each engine requests the RAM, is granted exclusive access for a burst of one-per-cycle read or write beats, and releases it. Read data returns to the granted engine with fixed latency. The block sits between the stage engines and the feature-map BRAM, beneath the stage-sequencing controller.

## Interface
- NREQ, 4, number of requesters; index 0 = conv, 1 = relu, 2 = pool, 3 = dense
- AW, 12, RAM address width
- DW, 16, RAM data width (signed Q-format, passed through untouched)
- MAX_BURST, 16, beat limit per grant (used only with the burst-limit feature)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester request; each requester holds it high while it has beats to issue
- last  in  NREQ  marks the final beat of a burst; sampled only when a beat is issued
- we  in  NREQ  per-requester write enable for the current beat
- addr  in  NREQ*AW  packed addresses; requester i occupies [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data, same packing as addr
- gnt  out  NREQ  one-hot grant, registered
- mem_en  out  1  RAM enable, registered
- mem_we  out  1  RAM write enable, registered
- mem_addr  out  AW  RAM address, registered
- mem_wdata  out  DW  RAM write data, registered
- mem_rdata  in  DW  RAM read data, 1-cycle latency after mem_en
- rvalid  out  NREQ  one-hot read-data valid, routed to the requester that issued the read
- rdata  out  DW  mem_rdata passed through combinationally
- busy  out  1  high while any grant is held or any beat is in flight

## Operation
- States: IDLE, GRANT.
- IDLE: if any req is high, pick a winner with the round-robin picker, starting at `ptr`. Set gnt[winner], clear the beat counter, go to GRANT. If no req is high, gnt=0.
- GRANT: a beat is issued when req[g] is high. For each beat, the block registers mem_en=1, mem_we=we[g], mem_addr=addr[g] and mem_wdata=wdata[g], and increments the beat counter.
- Release: GRANT goes to IDLE on any of these:
  - a beat is issued with last[g]=1
  - req[g] is low (the requester abandons the grant)
  - the burst limit is reached (see Configuration)
- On release: gnt is cleared and `ptr` is set to (g+1) mod NREQ.
- A non-granted requester's req, we, addr and wdata are ignored.
- `ptr` resets to 0. Ties are impossible because the picker scans from `ptr` upward with wrap-around.
- Read return: a tag pipeline records one-hot g for each read beat. rvalid[g] pulses in the cycle mem_rdata is valid. Write beats produce no rvalid.
- busy = (state==GRANT) | mem_en | any tag pipeline stage valid.

## Timing
- Reset values: gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid=0, busy=0, state=IDLE, ptr=0, beat count=0.
- Grant latency: req rising in IDLE at cycle t gives gnt high at t+1.
- Beat latency: a beat at cycle t gives mem_en at t+1. For a read, rvalid and rdata follow at t+2.
- Back-to-back bursts have a one-cycle IDLE bubble. A release at t clears gnt at t+1, and the next gnt appears at t+2 at the earliest.
- Full throughput inside a burst: one beat per cycle.
- A single-beat burst (last high on the first beat) is legal and uses one beat.
- Reset mid-burst: gnt, mem_en and the tag pipeline all clear on the next edge. No rvalid is emitted for reads in flight.

## Configuration
- ARB_BURST_LIMIT_EN defined:
  - the beat counter is `$clog2(MAX_BURST+1)` bits wide
  - the grant is force-released in the same cycle the MAX_BURST-th beat issues, even without last
  - the requester must re-request to continue
- ARB_BURST_LIMIT_EN undefined: no counter logic. Bursts are unbounded and end only on last or on req deassertion.

## Structure
- cnn_pkg holds:
  - the `arb_state_t` enum (IDLE, GRANT)
  - requester index constants REQ_CONV=0, REQ_RELU=1, REQ_POOL=2, REQ_DENSE=3
  - default AW/DW localparams shared with the stage engines
- Sub-module `rr_pick`: a combinational round-robin picker with inputs req[NREQ] and ptr, and output one-hot winner plus valid. It is instantiated once.

## Test plan
- Single requester: req[1]=1, reads at addresses 5,6,7, last on the third beat. Expected: gnt=0010 one cycle later; mem_addr=5,6,7 on consecutive cycles; rvalid[1] on three consecutive cycles two cycles after each beat; gnt clears, busy falls after the last rvalid.
- Contention: req=1111 held with 2-beat bursts. Expected: grant order 0,1,2,3,0 with a one-cycle gap between grants; no requester is granted twice before all others have been granted.
- Abandon: the granted requester drops req after 3 beats without last. Expected: exactly 3 mem_en pulses, then release, and ptr advances past that requester.
- Burst limit with ARB_BURST_LIMIT_EN and MAX_BURST=16: requester 2 streams 20 writes. Expected: gnt drops after 16 beats; the remaining 4 beats go out under a second grant. Without the macro: one 20-beat grant.
- Reset mid-read: reset asserted one cycle after a read beat. Expected: no rvalid; all outputs at reset values on the next cycle.
- Mixed read/write: requester 3 interleaves writes and reads. Expected: rvalid[3] only for read beats; mem_we matches we per beat.
